// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads and
// buffers returned words in a small FIFO presented to decode via valid/ready.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jump_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   LVL_ZERO = (CW+1)'(0);
  localparam logic [CW:0]   LVL_ONE  = (CW+1)'(1);
  localparam logic [CW:0]   LVL_MAX  = (CW+1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   req_pc_r;
  logic [31:0]   fifo_pc_r    [DEPTH];
  logic [31:0]   fifo_instr_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          outstanding_r;
  logic          drop_r;

  logic          out_valid_s;
  logic          pending_s;
  logic          accept_s;
  logic          pop_s;
  logic          push_s;
  logic          grant_s;
  logic [CW:0]   level_s;

  logic [31:0]   pc_nxt_s;
  logic [31:0]   req_pc_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic          outstanding_nxt_s;
  logic          drop_nxt_s;
  logic          jump_pc_unused_s;

  assign jump_pc_unused_s = ^jump_pc[1:0];
  assign imem_addr        = pc_r;
  assign out_valid        = out_valid_s;

  // Handshake qualifiers and the issue rule; level_s is the FIFO occupancy after this edge.
  always_comb begin
    out_valid_s = (count_r != CNT_ZERO);
    pending_s   = outstanding_r && !imem_rvalid;
    accept_s    = imem_rvalid && outstanding_r && !drop_r;
    pop_s       = out_valid_s && out_ready;
    push_s      = accept_s && !jump;
    level_s     = {1'b0, count_r} + (accept_s ? LVL_ONE : LVL_ZERO)
                                  - (pop_s    ? LVL_ONE : LVL_ZERO);
    imem_req    = !rst && !jump && !pending_s && (level_s < LVL_MAX);
    grant_s     = imem_req && imem_gnt;
  end

  // Next-state: a redirect flushes everything and wins over any push.
  always_comb begin
    pc_nxt_s          = pc_r;
    req_pc_nxt_s      = req_pc_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    count_nxt_s       = count_r;
    outstanding_nxt_s = outstanding_r;
    drop_nxt_s        = drop_r;
    if (jump) begin
      pc_nxt_s          = {jump_pc[31:2], 2'b00};
      rd_ptr_nxt_s      = PTR_ZERO;
      wr_ptr_nxt_s      = PTR_ZERO;
      count_nxt_s       = CNT_ZERO;
      // A response still in flight belongs to the old path and must be swallowed.
      outstanding_nxt_s = pending_s;
      drop_nxt_s        = pending_s;
    end else begin
      if (imem_rvalid && outstanding_r) begin
        outstanding_nxt_s = 1'b0;
        drop_nxt_s        = 1'b0;
      end else begin
        outstanding_nxt_s = outstanding_r;
        drop_nxt_s        = drop_r;
      end
      if (grant_s) begin
        outstanding_nxt_s = 1'b1;
        pc_nxt_s          = pc_r + 32'd4;
        req_pc_nxt_s      = pc_r;
      end else begin
        pc_nxt_s          = pc_r;
        req_pc_nxt_s      = req_pc_r;
      end
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      count_nxt_s = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      req_pc_r      <= RESET_PC;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      count_r       <= CNT_ZERO;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      req_pc_r      <= req_pc_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_r        <= drop_nxt_s;
    end
  end

  // FIFO storage of {pc, instr}, written on each accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]    <= 32'h0000_0000;
        fifo_instr_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_pc_r[wr_ptr_r]    <= req_pc_r;
      fifo_instr_r[wr_ptr_r] <= imem_rdata;
    end
  end

  // Head presentation; all data outputs read as zero while the FIFO is empty.
  always_comb begin
    if (out_valid_s) begin
      out_pc        = fifo_pc_r[rd_ptr_r];
      out_instr     = fifo_instr_r[rd_ptr_r];
      out_pc_plus_4 = fifo_pc_r[rd_ptr_r] + 32'd4;
    end else begin
      out_pc        = 32'h0000_0000;
      out_instr     = 32'h0000_0000;
      out_pc_plus_4 = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus randomized memory/decode/redirect traffic,
// all checked against a stream-level model of program order and the issue rule.
module tb_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump;
  logic [31:0] jump_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_instr;

  logic        jump_w;
  logic [31:0] jump_pc_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_gnt_w;
  logic        imem_rvalid_w;
  logic [31:0] imem_rdata_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [31:0] out_pc_w;
  logic [31:0] out_pc_plus_4_w;
  logic [31:0] out_instr_w;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_pc(jump_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4), .out_instr(out_instr)
  );

  fetch #(.RESET_PC(RPC_W), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .jump(jump_w), .jump_pc(jump_pc_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_pc(out_pc_w),
    .out_pc_plus_4(out_pc_plus_4_w), .out_instr(out_instr_w)
  );

  int checks = 0;
  int errors = 0;

  // memory model: in-order responses; stale marks wrong-path requests
  logic [31:0] q_addr[$];
  bit          q_stale[$];
  int          q_lat[$];
  int          orphan_lat = -1;
  logic [31:0] orphan_addr;

  // architectural model
  int          occ;
  logic [31:0] exp_issue;
  logic [31:0] exp_out;
  int          n_pop = 0;

  bit gnt_rand = 1'b0;
  bit gnt_force = 1'b1;
  int lat_fix = 0;

  bit          w_grant = 1'b0;
  logic [31:0] w_gaddr = 32'h0;

  logic        s_req, s_valid, s_rvalid, s_grant;
  logic [31:0] s_addr, s_pc, s_pc4, s_instr;
  logic        sw_req, sw_valid;
  logic [31:0] sw_addr, sw_pc, sw_pc4, sw_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'hC0DE_5A5A) + {a[7:0], a[31:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory, sample at negedge, check against the model, advance.
  task automatic step();
    bit rv_q, rv_o, acc, popx, pend, req_e, exp_v, grant_e;
    rv_q = (q_addr.size() > 0) && (q_lat[0] == 0);
    rv_o = (orphan_lat == 0);
    imem_rvalid = rv_q || rv_o;
    imem_rdata  = rv_q ? instr_of(q_addr[0]) : (rv_o ? instr_of(orphan_addr) : $urandom);
    imem_gnt    = gnt_rand ? ($urandom_range(0, 9) < 7) : gnt_force;
    imem_rvalid_w = w_grant;
    imem_rdata_w  = instr_of(w_gaddr);
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc;
    s_pc4 = out_pc_plus_4; s_instr = out_instr; s_rvalid = imem_rvalid;
    s_grant = imem_req && imem_gnt;
    sw_req = imem_req_w; sw_addr = imem_addr_w; sw_valid = out_valid_w;
    sw_pc = out_pc_w; sw_pc4 = out_pc_plus_4_w; sw_instr = out_instr_w;
    w_grant = sw_req && imem_gnt_w;
    w_gaddr = sw_addr;
    grant_e = 1'b0;
    if (rst) begin
      chk1("rst_valid", s_valid, 1'b0);
      chk1("rst_req", s_req, 1'b0);
      chk("rst_addr", s_addr, RPC);
      chk("rst_pc", s_pc, 32'h0);
      if (q_addr.size() > 0) begin
        orphan_lat  = q_lat[0];
        orphan_addr = q_addr[0];
      end
      q_addr.delete(); q_stale.delete(); q_lat.delete();
      occ = 0; exp_issue = RPC; exp_out = RPC;
    end else begin
      exp_v = (occ != 0);
      pend  = (q_addr.size() > 0) && !rv_q;
      acc   = rv_q && !q_stale[0];
      popx  = exp_v && out_ready;
      req_e = !jump && !pend && ((occ + int'(acc) - int'(popx)) < DEPTH);
      grant_e = req_e && imem_gnt;
      chk1("valid", s_valid, exp_v);
      chk1("req", s_req, req_e);
      chk("addr", s_addr, exp_issue);
      if (popx) begin
        chk("out_pc", s_pc, exp_out);
        chk("out_instr", s_instr, instr_of(exp_out));
        chk("out_pc4", s_pc4, exp_out + 32'd4);
        exp_out = exp_out + 32'd4;
        n_pop++;
      end else if (!exp_v) begin
        chk("empty_pc", s_pc, 32'h0);
        chk("empty_instr", s_instr, 32'h0);
        chk("empty_pc4", s_pc4, 32'h0);
      end
      if (rv_q) begin
        void'(q_addr.pop_front()); void'(q_stale.pop_front()); void'(q_lat.pop_front());
      end
      if (jump) begin
        occ = 0;
        exp_issue = {jump_pc[31:2], 2'b00};
        exp_out   = exp_issue;
        foreach (q_stale[i]) q_stale[i] = 1'b1;
      end else begin
        occ = occ + int'(acc) - int'(popx);
        if (grant_e) exp_issue = exp_issue + 32'd4;
      end
    end
    if (rv_o) orphan_lat = -1;
    foreach (q_lat[i]) if (q_lat[i] > 0) q_lat[i] = q_lat[i] - 1;
    if (orphan_lat > 0) orphan_lat = orphan_lat - 1;
    if (s_grant) begin
      q_addr.push_back(s_addr);
      q_stale.push_back(1'b0);
      q_lat.push_back(lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump = 1'b0;
    repeat (5) step();
    rst = 1'b0;
  endtask

  int          ng;
  logic [31:0] ga0, ga1, fpc;
  bit          found, seen;
  int          p0;

  initial begin
    rst = 1'b1; jump = 1'b0; jump_pc = 32'h0; out_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    jump_w = 1'b0; jump_pc_w = 32'h0; imem_gnt_w = 1'b1; out_ready_w = 1'b1;
    imem_rvalid_w = 1'b0; imem_rdata_w = 32'h0;
    ga0 = 32'h0; ga1 = 32'h0; fpc = 32'h0;

    // zero-wait streaming from reset, plus PC wrap on the second instance
    do_reset();
    step();
    chk1("t1_req0", s_req, 1'b1);
    chk("t1_addr0", s_addr, 32'h0000_0100);
    chk1("t1_nv0", s_valid, 1'b0);
    chk("t6_addr0", sw_addr, 32'hFFFF_FFFC);
    step();
    chk("t1_addr1", s_addr, 32'h0000_0104);
    chk1("t1_nv1", s_valid, 1'b0);
    chk("t6_addr1", sw_addr, 32'h0000_0000);
    step();
    chk("t1_addr2", s_addr, 32'h0000_0108);
    chk1("t1_v2", s_valid, 1'b1);
    chk("t1_pc2", s_pc, 32'h0000_0100);
    chk("t1_pc4_2", s_pc4, 32'h0000_0104);
    chk1("t6_v2", sw_valid, 1'b1);
    chk("t6_pc", sw_pc, 32'hFFFF_FFFC);
    chk("t6_pc4", sw_pc4, 32'h0000_0000);
    chk("t6_instr", sw_instr, instr_of(32'hFFFF_FFFC));
    step();
    chk1("t1_v3", s_valid, 1'b1);
    chk("t1_pc3", s_pc, 32'h0000_0104);

    // backpressure fills the FIFO after exactly DEPTH grants
    out_ready = 1'b0;
    do_reset();
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_grant) begin
        if (ng == 0) ga0 = s_addr;
        if (ng == 1) ga1 = s_addr;
        ng++;
      end
    end
    chk("t2_grants", 32'(ng), 32'd2);
    chk("t2_ga0", ga0, 32'h0000_0100);
    chk("t2_ga1", ga1, 32'h0000_0104);
    chk1("t2_req_off", s_req, 1'b0);
    out_ready = 1'b1;
    step();
    chk1("t2_req_on", s_req, 1'b1);
    chk("t2_resume", s_addr, 32'h0000_0108);
    chk("t2_head", s_pc, 32'h0000_0100);
    repeat (6) step();

    // redirect while a slow response is pending
    lat_fix = 2;
    do_reset();
    step();
    jump = 1'b1; jump_pc = 32'h0000_0203;
    step();
    chk1("t3_req_jump", s_req, 1'b0);
    jump = 1'b0;
    step();
    chk1("t3_flush", s_valid, 1'b0);
    chk1("t3_req_pend", s_req, 1'b0);
    step();
    chk1("t3_drop_rv", s_rvalid, 1'b1);
    chk1("t3_regrant", s_grant, 1'b1);
    chk("t3_addr", s_addr, 32'h0000_0200);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (s_valid) begin found = 1'b1; fpc = s_pc; end
    end
    chk1("t3_found", found, 1'b1);
    chk("t3_first", fpc, 32'h0000_0200);

    // redirect in the same cycle as the response for 0x104
    lat_fix = 0;
    do_reset();
    step();
    step();
    jump = 1'b1; jump_pc = 32'h0000_0300;
    step();
    chk1("t4_rv", s_rvalid, 1'b1);
    chk1("t4_req", s_req, 1'b0);
    chk("t4_pop_pc", s_pc, 32'h0000_0100);
    jump = 1'b0;
    step();
    chk1("t4_flush", s_valid, 1'b0);
    chk1("t4_req1", s_req, 1'b1);
    chk("t4_addr", s_addr, 32'h0000_0300);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_valid && s_pc == 32'h0000_0104) seen = 1'b1;
    end
    chk1("t4_no104", seen, 1'b0);

    // reset mid-flight; the stale response lands after release
    lat_fix = 2;
    do_reset();
    step();
    gnt_force = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk1("t5_v0", s_valid, 1'b0);
    step();
    chk1("t5_stale_rv", s_rvalid, 1'b1);
    chk1("t5_v1", s_valid, 1'b0);
    step();
    chk1("t5_v2", s_valid, 1'b0);
    gnt_force = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (s_valid) begin found = 1'b1; fpc = s_pc; end
    end
    chk1("t5_found", found, 1'b1);
    chk("t5_first", fpc, 32'h0000_0100);

    // randomized traffic against the model
    lat_fix = -1;
    gnt_rand = 1'b1;
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        jump = 1'b1;
        jump_pc = $urandom;
      end else begin
        jump = 1'b0;
      end
      step();
    end
    jump = 1'b0;
    chk1("rand_progress", (n_pop - p0) > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
